// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
//   Handshaked ALU between operand fetch and writeback. Single-cycle ops
//   (logic, add/sub, shifts, set-less-than) register their result one edge
//   after accept. MUL/MULHU use a shift-add multiplier and DIVU/REMU use a
//   restoring divider, both retiring one bit per cycle. Every result sits in
//   an output register that is held until the consumer takes it.
//
//   XLEN must be >= 8 and a power of 2. SHW is derived from XLEN.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   in_valid   operands and op are valid this cycle
//   in_ready   block can accept an operation this cycle
//   alu_in1    operand A
//   alu_in2    operand B (shifts use alu_in2[SHW-1:0])
//   alu_ctrl   operation select
//   out_valid  alu_out/alu_zero hold a valid result
//   out_ready  consumer takes the result this cycle
//   alu_out    registered result
//   alu_zero   registered flag, high when alu_out == 0
//   busy       multi-cycle operation in progress
// -----------------------------------------------------------------------------
module seq_alu #(
   parameter  int XLEN = 32,
   localparam int SHW  = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] alu_in1,
   input  logic [XLEN-1:0] alu_in2,
   input  logic [3:0]      alu_ctrl,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] alu_out,
   output logic            alu_zero,
   output logic            busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_XOR   = 4'b0011;
   localparam logic [3:0] OP_SLL   = 4'b0100;
   localparam logic [3:0] OP_SRL   = 4'b0101;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_SRA   = 4'b0111;
   localparam logic [3:0] OP_SLT   = 4'b1000;
   localparam logic [3:0] OP_SLTU  = 4'b1001;
   localparam logic [3:0] OP_MUL   = 4'b1010;
   localparam logic [3:0] OP_MULHU = 4'b1011;
   localparam logic [3:0] OP_DIVU  = 4'b1100;
   localparam logic [3:0] OP_REMU  = 4'b1101;

   state_t state, next_state;

   logic [SHW-1:0]    cnt;
   logic [XLEN-1:0]   a_reg;      // multiplicand
   logic [XLEN-1:0]   b_reg;      // divisor
   logic [2*XLEN-1:0] prod;       // {partial high, remaining multiplier / low product}
   logic [XLEN-1:0]   rem;
   logic [XLEN-1:0]   quo;        // dividend bits shift out as quotient bits shift in
   logic              op_div;     // 1: divider result, 0: multiplier result
   logic              op_hi;      // 1: MULHU / REMU word

   logic            accept;
   logic            is_multi;
   logic            out_free;
   logic            done_fire;
   logic [SHW-1:0]  shamt;
   logic [XLEN-1:0] single_res;
   logic [XLEN-1:0] multi_res;
   logic [XLEN:0]   mul_sum;
   logic [2*XLEN-1:0] mul_next;
   logic [XLEN:0]   div_shift;
   logic            div_ge;
   logic [XLEN-1:0] rem_next;
   logic [XLEN-1:0] quo_next;

   // Output register can take a new result when empty or being drained now.
   assign out_free  = !out_valid || out_ready;
   assign in_ready  = (state == S_IDLE) && out_free;
   assign accept    = in_valid && in_ready;
   assign is_multi  = (alu_ctrl == OP_MUL)  || (alu_ctrl == OP_MULHU) ||
                      (alu_ctrl == OP_DIVU) || (alu_ctrl == OP_REMU);
   assign done_fire = (state == S_DONE) && out_free;
   assign busy      = (state != S_IDLE);
   assign shamt     = alu_in2[SHW-1:0];

   // ---------------------------------------------------------------------------
   // Single-cycle result
   // ---------------------------------------------------------------------------
   // NOTE: every always_comb output gets a default first so no path can leave
   // it unassigned and infer a latch.
   always_comb begin
      single_res = '0;
      unique case (alu_ctrl)
         OP_AND:  single_res = alu_in1 & alu_in2;
         OP_OR:   single_res = alu_in1 | alu_in2;
         OP_ADD:  single_res = alu_in1 + alu_in2;
         OP_SUB:  single_res = alu_in1 - alu_in2;
         OP_XOR:  single_res = alu_in1 ^ alu_in2;
         OP_SLL:  single_res = alu_in1 << shamt;
         OP_SRL:  single_res = alu_in1 >> shamt;
         OP_SRA:  single_res = $signed(alu_in1) >>> shamt;
         OP_SLT:  single_res = {{(XLEN-1){1'b0}}, $signed(alu_in1) < $signed(alu_in2)};
         OP_SLTU: single_res = {{(XLEN-1){1'b0}}, alu_in1 < alu_in2};
         default: single_res = '0;   // multi-cycle ops and reserved codes
      endcase
   end

   // ---------------------------------------------------------------------------
   // Iteration datapath
   // ---------------------------------------------------------------------------
   // Shift-add: conditionally add the multiplicand into the high half, then
   // shift the whole product right; the carry bit lands in the top position.
   assign mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, (prod[0] ? a_reg : '0)};
   assign mul_next = {mul_sum, prod[XLEN-1:1]};

   // Restoring divide: bring the next dividend bit into the remainder and
   // subtract the divisor if it fits. A zero divisor always "fits", which
   // yields an all-ones quotient and leaves the dividend in the remainder.
   assign div_shift = {rem, quo[XLEN-1]};
   assign div_ge    = (div_shift >= {1'b0, b_reg});
   assign rem_next  = div_ge ? (div_shift[XLEN-1:0] - b_reg) : div_shift[XLEN-1:0];
   assign quo_next  = {quo[XLEN-2:0], div_ge};

   always_comb begin
      multi_res = '0;
      if (op_div) multi_res = op_hi ? rem : quo;
      else        multi_res = op_hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
   end

   // ---------------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------------
   always_comb begin
      next_state = state;
      unique case (state)
         S_IDLE: if (accept && is_multi) next_state = alu_ctrl[2] ? S_DIV : S_MUL;
         S_MUL,
         S_DIV:  if (cnt == SHW'(XLEN-1)) next_state = S_DONE;
         S_DONE: if (out_free) next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples values from before the edge, independent of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= next_state;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt    <= '0;
         a_reg  <= '0;
         b_reg  <= '0;
         prod   <= '0;
         rem    <= '0;
         quo    <= '0;
         op_div <= 1'b0;
         op_hi  <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (accept && is_multi) begin
                  cnt    <= '0;
                  a_reg  <= alu_in1;
                  b_reg  <= alu_in2;
                  prod   <= {{XLEN{1'b0}}, alu_in2};
                  rem    <= '0;
                  quo    <= alu_in1;
                  op_div <= alu_ctrl[2];
                  op_hi  <= alu_ctrl[0];
               end
            end
            S_MUL: begin
               prod <= mul_next;
               cnt  <= cnt + 1'b1;
            end
            S_DIV: begin
               rem <= rem_next;
               quo <= quo_next;
               cnt <= cnt + 1'b1;
            end
            default: ;   // S_DONE holds the finished operands
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Output register
   // ---------------------------------------------------------------------------
   // A single-cycle accept and a DONE completion cannot coincide: DONE keeps
   // in_ready low.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         alu_out   <= '0;
         alu_zero  <= 1'b0;
      end else if (accept && !is_multi) begin
         out_valid <= 1'b1;
         alu_out   <= single_res;
         alu_zero  <= (single_res == '0);
      end else if (done_fire) begin
         out_valid <= 1'b1;
         alu_out   <= multi_res;
         alu_zero  <= (multi_res == '0);
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu
//   Directed bench for seq_alu: a 32-bit instance for the main behaviour and a
//   16-bit instance for the narrow build. Outputs are sampled on the falling
//   edge; inputs change right after sampling.
// -----------------------------------------------------------------------------
module tb_seq_alu;

   logic        clk;
   logic        reset;
   logic        out_ready;
   logic [31:0] alu_in1;
   logic [31:0] alu_in2;
   logic [3:0]  alu_ctrl;

   logic        in_valid;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] alu_out;
   logic        alu_zero;
   logic        busy;

   logic        in_valid16;
   logic        in_ready16;
   logic        out_valid16;
   logic [15:0] alu_out16;
   logic        alu_zero16;
   logic        busy16;

   int n_tests = 0;
   int n_fail  = 0;

   seq_alu #(.XLEN(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_in1   (alu_in1),
      .alu_in2   (alu_in2),
      .alu_ctrl  (alu_ctrl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .alu_out   (alu_out),
      .alu_zero  (alu_zero),
      .busy      (busy)
   );

   seq_alu #(.XLEN(16)) dut16 (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid16),
      .in_ready  (in_ready16),
      .alu_in1   (alu_in1[15:0]),
      .alu_in2   (alu_in2[15:0]),
      .alu_ctrl  (alu_ctrl),
      .out_valid (out_valid16),
      .out_ready (out_ready),
      .alu_out   (alu_out16),
      .alu_zero  (alu_zero16),
      .busy      (busy16)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Observation mux so one task can drive either instance.
   logic        sel16;
   logic        obs_valid;
   logic        obs_ready;
   logic        obs_busy;
   logic        obs_zero;
   logic [31:0] obs_out;
   assign obs_valid = sel16 ? out_valid16 : out_valid;
   assign obs_ready = sel16 ? in_ready16  : in_ready;
   assign obs_busy  = sel16 ? busy16      : busy;
   assign obs_zero  = sel16 ? alu_zero16  : alu_zero;
   assign obs_out   = sel16 ? {16'h0000, alu_out16} : alu_out;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issues one op (caller is at a falling edge with the target idle) and
   // checks the result, its latency in edges after the accept edge, and that
   // the block stalled its input throughout a multi-cycle op.
   task automatic run_op(input bit w16, input string tag, input logic [3:0] ctrl,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat);
      int  edges;
      bit  ready_seen;
      bit  busy_low;
      sel16     = w16;
      out_ready = 1'b1;
      alu_ctrl  = ctrl;
      alu_in1   = a;
      alu_in2   = b;
      if (w16) in_valid16 = 1'b1;
      else     in_valid   = 1'b1;
      @(negedge clk);
      in_valid   = 1'b0;
      in_valid16 = 1'b0;
      // Scramble inputs: changes while busy must be ignored.
      alu_ctrl   = 4'b0000;
      alu_in1    = 32'hDEAD_BEEF;
      alu_in2    = 32'h0000_0003;
      edges      = 0;
      ready_seen = 1'b0;
      busy_low   = 1'b0;
      while (!obs_valid && edges < 200) begin
         if (obs_ready) ready_seen = 1'b1;
         if (!obs_busy) busy_low = 1'b1;
         @(negedge clk);
         edges++;
      end
      check({tag, " latency"}, 64'(edges), 64'(lat));
      check({tag, " result"}, 64'(obs_out), 64'(exp));
      check({tag, " zero"}, 64'(obs_zero), 64'(exp == 32'h0));
      if (lat > 0) begin
         check({tag, " stall"}, {62'h0, ready_seen, busy_low}, 64'h0);
         check({tag, " busy end"}, 64'(obs_busy), 64'h0);
      end
      @(negedge clk);
      check({tag, " drained"}, 64'(obs_valid), 64'h0);
      sel16 = 1'b0;
   endtask

   typedef struct {
      string       tag;
      logic [3:0]  ctrl;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
   } vec_t;

   vec_t vecs[11];

   initial begin
      bit seen;

      vecs[0]  = '{"ADD wrap", 4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
      vecs[1]  = '{"SUB",      4'b0110, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE};
      vecs[2]  = '{"SRA",      4'b0111, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000};
      vecs[3]  = '{"SLT",      4'b1000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
      vecs[4]  = '{"SLTU",     4'b1001, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
      vecs[5]  = '{"XOR",      4'b0011, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0};
      vecs[6]  = '{"SLL",      4'b0100, 32'h0000_0001, 32'h0000_003F, 32'h8000_0000};
      vecs[7]  = '{"SRL",      4'b0101, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001};
      vecs[8]  = '{"AND",      4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000};
      vecs[9]  = '{"OR",       4'b0001, 32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF};
      vecs[10] = '{"RSVD",     4'b1110, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000};

      sel16      = 1'b0;
      reset      = 1'b0;
      in_valid   = 1'b0;
      in_valid16 = 1'b0;
      out_ready  = 1'b0;
      alu_in1    = '0;
      alu_in2    = '0;
      alu_ctrl   = '0;

      // ---- reset state ----
      @(negedge clk);
      check("rst out_valid", 64'(out_valid), 64'h0);
      check("rst alu_out",   64'(alu_out),   64'h0);
      check("rst alu_zero",  64'(alu_zero),  64'h0);
      check("rst busy",      64'(busy),      64'h0);
      check("rst in_ready",  64'(in_ready),  64'h1);
      reset = 1'b1;
      @(negedge clk);

      // ---- single-cycle stream, in_valid held high, consumer at full rate ----
      out_ready = 1'b1;
      alu_ctrl  = vecs[0].ctrl;
      alu_in1   = vecs[0].a;
      alu_in2   = vecs[0].b;
      in_valid  = 1'b1;
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         check({vecs[i].tag, " valid"}, 64'(out_valid), 64'h1);
         check({vecs[i].tag, " out"},   64'(alu_out),   64'(vecs[i].r));
         check({vecs[i].tag, " zero"},  64'(alu_zero),  64'(vecs[i].r == 32'h0));
         check({vecs[i].tag, " ready"}, 64'(in_ready),  64'h1);
         if (i < 10) begin
            alu_ctrl = vecs[i+1].ctrl;
            alu_in1  = vecs[i+1].a;
            alu_in2  = vecs[i+1].b;
         end else begin
            in_valid = 1'b0;
         end
      end
      @(negedge clk);
      check("stream drained", 64'(out_valid), 64'h0);

      // ---- multi-cycle ops ----
      run_op(1'b0, "MUL",       4'b1010, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 33);
      run_op(1'b0, "MUL neg",   4'b1010, 32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFD, 33);
      run_op(1'b0, "MULHU",     4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
      run_op(1'b0, "DIVU",      4'b1100, 32'd100,       32'd7,         32'd14,        33);
      run_op(1'b0, "REMU",      4'b1101, 32'd100,       32'd7,         32'd2,         33);
      run_op(1'b0, "DIVU by 0", 4'b1100, 32'd5,         32'd0,         32'hFFFF_FFFF, 33);
      run_op(1'b0, "REMU by 0", 4'b1101, 32'd5,         32'd0,         32'd5,         33);

      // ---- reset during MUL iteration ----
      out_ready = 1'b1;
      alu_ctrl  = 4'b1010;
      alu_in1   = 32'h0000_0003;
      alu_in2   = 32'h0000_0005;
      in_valid  = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      check("pre-rst busy", 64'(busy), 64'h1);
      #2 reset = 1'b0;
      #1;
      check("midrst out_valid", 64'(out_valid), 64'h0);
      check("midrst busy",      64'(busy),      64'h0);
      check("midrst in_ready",  64'(in_ready),  64'h1);
      @(negedge clk);
      reset = 1'b1;
      seen  = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid || busy) seen = 1'b1;
      end
      check("no stale result", 64'(seen), 64'h0);

      // ---- backpressure ----
      out_ready = 1'b0;
      alu_ctrl  = 4'b0010;
      alu_in1   = 32'd3;
      alu_in2   = 32'd4;
      in_valid  = 1'b1;
      @(negedge clk);
      check("bp first out", 64'(alu_out), 64'd7);
      alu_ctrl = 4'b0011;
      alu_in1  = 32'h0000_00F0;
      alu_in2  = 32'h0000_000F;
      for (int i = 0; i < 5; i++) begin
         check("bp in_ready",  64'(in_ready),  64'h0);
         check("bp held out",  64'(alu_out),   64'd7);
         check("bp held vld",  64'(out_valid), 64'h1);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("bp next valid", 64'(out_valid), 64'h1);
      check("bp next out",   64'(alu_out),   64'h0000_00FF);
      @(negedge clk);
      check("bp drained",    64'(out_valid), 64'h0);

      // ---- 16-bit build ----
      run_op(1'b1, "X16 ADD",   4'b0010, 32'h0000_FFFF, 32'h0000_0002, 32'h0000_0001, 0);
      run_op(1'b1, "X16 MUL",   4'b1010, 32'h0000_0100, 32'h0000_0100, 32'h0000_0000, 17);
      run_op(1'b1, "X16 MULHU", 4'b1011, 32'h0000_0100, 32'h0000_0100, 32'h0000_0001, 17);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
